// File: rtl/run_stream_if.sv
// Command/stream bundle for run_stream_tx; signal prefixes are from the transmitter's view.
interface run_stream_if #(
  parameter int LEN_W = 4
);
  logic             i_cmd_valid;
  logic             o_cmd_ready;
  logic             i_cmd_bit;
  logic [LEN_W-1:0] i_cmd_len;
  logic             o_w;
  logic             o_busy;
  logic             o_done;
  logic             o_exp_z;

  modport master (
    output i_cmd_valid, i_cmd_bit, i_cmd_len,
    input  o_cmd_ready, o_w, o_busy, o_done, o_exp_z
  );

  modport slave (
    input  i_cmd_valid, i_cmd_bit, i_cmd_len,
    output o_cmd_ready, o_w, o_busy, o_done, o_exp_z
  );
endinterface

// File: rtl/run_stream_tx.sv
// Run-length serial transmitter: expands {bit, len} commands into a contiguous stream on o_w.
// Optional detector reference model on o_exp_z is compiled in with RUN_STREAM_EXPZ_EN.
//
// state  | meaning
// S_IDLE | no run in progress, o_w holds the last bit sent
// S_SEND | emitting a run, r_rem bits left after the current one
module run_stream_tx #(
  parameter int LEN_W = 4
) (
  input  logic         i_clock,
  input  logic         i_reset,
  run_stream_if.slave  bus
);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t           r_state;
  logic [LEN_W-1:0] r_rem;
  logic             r_w;
  logic             r_zero_done;

  state_t           w_state_nxt;
  logic [LEN_W-1:0] w_rem_nxt;
  logic             w_w_nxt;
  logic             w_zero_done_nxt;
  logic             w_last;
  logic             w_accept;

  assign w_last   = (r_state == S_SEND) && (r_rem == '0);
  assign w_accept = bus.i_cmd_valid && bus.o_cmd_ready;

  assign bus.o_cmd_ready = (r_state == S_IDLE) || w_last;
  assign bus.o_busy      = (r_state == S_SEND);
  // Suppressed under reset so an abandoned command never reports completion.
  assign bus.o_done      = ~i_reset & (w_last | r_zero_done);
  assign bus.o_w         = r_w;

  always_comb begin
    w_state_nxt     = r_state;
    w_rem_nxt       = r_rem;
    w_w_nxt         = r_w;
    w_zero_done_nxt = 1'b0;
    if (w_accept) begin
      if (bus.i_cmd_len != '0) begin
        w_state_nxt = S_SEND;
        w_rem_nxt   = bus.i_cmd_len - LEN_W'(1);
        w_w_nxt     = bus.i_cmd_bit;
      end else begin
        w_state_nxt     = S_IDLE;
        w_rem_nxt       = '0;
        w_zero_done_nxt = 1'b1;
      end
    end else if (r_state == S_SEND) begin
      if (r_rem != '0) begin
        w_rem_nxt = r_rem - LEN_W'(1);
      end else begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_w         <= 1'b0;
      r_zero_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rem       <= w_rem_nxt;
      r_w         <= w_w_nxt;
      r_zero_done <= w_zero_done_nxt;
    end
  end

`ifdef RUN_STREAM_EXPZ_EN
  // Mirrors the detector: Z is registered one edge after the run count reaches four.
  logic       r_run_bit;
  logic [2:0] r_run_cnt;
  logic       r_exp_z;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_run_bit <= 1'b0;
      r_run_cnt <= 3'd0;
      r_exp_z   <= 1'b0;
    end else begin
      r_exp_z <= (r_run_cnt == 3'd4);
      if ((r_run_cnt == 3'd0) || (r_w != r_run_bit)) begin
        r_run_bit <= r_w;
        r_run_cnt <= 3'd1;
      end else if (r_run_cnt != 3'd4) begin
        r_run_cnt <= r_run_cnt + 3'd1;
      end
    end
  end

  assign bus.o_exp_z = r_exp_z;
`else
  assign bus.o_exp_z = 1'b0;
`endif

endmodule
